// File: rtl/spu_adsr_env.sv
// Single-voice ADSR envelope generator: fetches a per-sample step from the rate-table ROM and advances a 15-bit level.
// Define ENV_EXP_EN to build exponential decrease (step scaled by level) and the exponential +8 rate boost.
module spu_adsr_env (
  input  logic        m_clock,
  input  logic        p_reset,
  input  logic        sample_tick,
  input  logic        key_on,
  input  logic        key_off,
  input  logic [6:0]  attack_rate,
  input  logic        attack_exp,
  input  logic [3:0]  decay_shift,
  input  logic [3:0]  sustain_level,
  input  logic [6:0]  sustain_rate,
  input  logic        sustain_dir,
  input  logic        sustain_exp,
  input  logic [4:0]  release_shift,
  input  logic        release_exp,
  output logic [6:0]  rom_adrs,
  output logic        rom_read,
  input  logic [13:0] rom_dout,
  output logic [14:0] env_level,
  output logic [2:0]  env_phase,
  output logic        env_valid
);

  localparam logic [2:0]  PH_OFF     = 3'd0;
  localparam logic [2:0]  PH_ATTACK  = 3'd1;
  localparam logic [2:0]  PH_DECAY   = 3'd2;
  localparam logic [2:0]  PH_SUSTAIN = 3'd3;
  localparam logic [2:0]  PH_RELEASE = 3'd4;
  localparam logic [14:0] LEVEL_MAX  = 15'h7FFF;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_FETCH, S_CALC} pipe_state_t;

  pipe_state_t state, state_next;

  logic [13:0] step;
  logic [13:0] step_next;
  logic        key_start;
  logic        key_release;
  logic        key_abort;
  logic        tick_accept;
  logic        load_adrs;
  logic        load_step;
  logic        load_level;
  logic        level_up;
  logic [6:0]  rate_adrs;
  logic [15:0] level_sum;
  logic [15:0] level_diff;
  logic [15:0] sustain_target;
  logic [14:0] level_next;
  logic [2:0]  phase_next;

  // key_on dominates key_off; key_off only matters while a note is sounding
  assign key_start   = key_on;
  assign key_release = key_off && !key_on && (env_phase != PH_OFF);
  assign key_abort   = key_start || key_release;
  assign tick_accept = sample_tick && (env_phase != PH_OFF);
  assign level_up    = (env_phase == PH_ATTACK) || ((env_phase == PH_SUSTAIN) && !sustain_dir);

`ifdef ENV_EXP_EN
  logic        level_high;
  logic        step_is_exp;
  logic [13:0] exp_step;
  logic [14:0] unused_exp_frac;

  function automatic logic [6:0] sat_plus8(input logic [6:0] rate);
    logic [7:0] boosted;
    boosted = {1'b0, rate} + 8'd8;
    return boosted[7] ? 7'h7F : boosted[6:0];
  endfunction

  assign level_high = env_level > 15'h6000;
  assign step_is_exp = (env_phase == PH_DECAY)
                    || ((env_phase == PH_SUSTAIN) && sustain_dir && sustain_exp)
                    || ((env_phase == PH_RELEASE) && release_exp);
  assign {exp_step, unused_exp_frac} = 29'(rom_dout) * 29'(env_level);
  assign step_next = step_is_exp ? exp_step : rom_dout;
`else
  logic unused_exp_inputs;

  assign unused_exp_inputs = ^{attack_exp, sustain_exp, release_exp};
  assign step_next = rom_dout;
`endif

  always_comb begin
    case (env_phase)
      PH_DECAY:   rate_adrs = {decay_shift, 2'b00};
      PH_SUSTAIN: rate_adrs = sustain_rate;
      PH_RELEASE: rate_adrs = {release_shift, 2'b00};
      default:    rate_adrs = attack_rate;
    endcase
`ifdef ENV_EXP_EN
    // Exponential increase slows down near the top by stepping to a slower rate entry
    if (level_high && (((env_phase == PH_ATTACK) && attack_exp) ||
                       ((env_phase == PH_SUSTAIN) && sustain_exp && !sustain_dir)))
      rate_adrs = sat_plus8(rate_adrs);
`endif
  end

  always_comb begin
    level_sum      = {1'b0, env_level} + {2'b00, step};
    level_diff     = {1'b0, env_level} - {2'b00, step};
    sustain_target = ({12'd0, sustain_level} + 16'd1) << 11;
    if (sustain_target > 16'h7FFF)
      sustain_target = 16'h7FFF;
    if (level_up)
      level_next = level_sum[15] ? LEVEL_MAX : level_sum[14:0];
    else
      level_next = level_diff[15] ? 15'd0 : level_diff[14:0];
    phase_next = env_phase;
    case (env_phase)
      PH_ATTACK:  if (level_next == LEVEL_MAX) phase_next = PH_DECAY;
      PH_DECAY:   if ({1'b0, level_next} <= sustain_target) phase_next = PH_SUSTAIN;
      PH_RELEASE: if (level_next == 15'd0) phase_next = PH_OFF;
      default:    phase_next = env_phase;
    endcase
  end

  always_ff @(posedge m_clock) begin
    if (p_reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (key_abort)
      state_next = S_IDLE;
    else begin
      case (state)
        S_IDLE:  if (tick_accept) state_next = S_ADDR;
        S_ADDR:  state_next = S_FETCH;
        S_FETCH: state_next = S_CALC;
        S_CALC:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Key events drop whatever the pipeline was doing, including a tick seen the same cycle
  always_comb begin
    load_adrs  = 1'b0;
    load_step  = 1'b0;
    load_level = 1'b0;
    if (!key_abort) begin
      case (state)
        S_IDLE:  load_adrs  = tick_accept;
        S_FETCH: load_step  = 1'b1;
        S_CALC:  load_level = 1'b1;
        default: load_adrs  = 1'b0;
      endcase
    end
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      env_level <= '0;
      env_phase <= PH_OFF;
      rom_adrs  <= '0;
      rom_read  <= 1'b0;
      env_valid <= 1'b0;
      step      <= '0;
    end else begin
      rom_read  <= load_adrs;
      env_valid <= load_level;
      if (load_adrs)
        rom_adrs <= rate_adrs;
      if (load_step)
        step <= step_next;
      if (key_start) begin
        env_level <= '0;
        env_phase <= PH_ATTACK;
      end else if (key_release)
        env_phase <= PH_RELEASE;
      else if (load_level) begin
        env_level <= level_next;
        env_phase <= phase_next;
      end
    end
  end

endmodule

// File: doc/spu_adsr_env.md
# spu_adsr_env

Single-voice ADSR envelope generator for the SPU. It consumes the synchronous rate-table ROM: it drives the 7-bit rate address and receives the 14-bit per-sample step one cycle later. Once per sample it advances a 15-bit envelope level through the Attack, Decay, Sustain and Release phases. The output level feeds the voice volume multiplier.

## Interface
Parameters:
- None. All widths are fixed by the SPU register format.

Ports:
- m_clock  in  1  system clock
- p_reset  in  1  reset, synchronous and active-high
- sample_tick  in  1  one-cycle strobe per output sample; consecutive ticks are at least 5 cycles apart
- key_on  in  1  one-cycle strobe that starts the envelope
- key_off  in  1  one-cycle strobe that starts release
- attack_rate  in  7  attack rate, used as ROM address
- attack_exp  in  1  1 = exponential attack
- decay_shift  in  4  decay ROM address = {decay_shift,2'b00}; decay is always exponential
- sustain_level  in  4  sustain target = min((sustain_level+1)<<11, 0x7FFF)
- sustain_rate  in  7  sustain ROM address
- sustain_dir  in  1  1 = decrease, 0 = increase
- sustain_exp  in  1  1 = exponential
- release_shift  in  5  release ROM address = {release_shift,2'b00}
- release_exp  in  1  1 = exponential release
- rom_adrs  out  7  rate-table address (registered)
- rom_read  out  1  read enable to the ROM
- rom_dout  in  14  rate-table step, valid the cycle after rom_adrs/rom_read are presented
- env_level  out  15  envelope level, 0..0x7FFF
- env_phase  out  3  0=OFF, 1=ATTACK, 2=DECAY, 3=SUSTAIN, 4=RELEASE
- env_valid  out  1  one-cycle pulse when env_level has updated

## Operation
- Pipeline FSM states: IDLE → ADDR → FETCH → CALC → IDLE.
  - IDLE: on sample_tick with env_phase≠OFF, register rom_adrs, set rom_read=1, go to ADDR.
  - ADDR: the ROM samples the address. Drop rom_read. Go to FETCH.
  - FETCH: rom_dout is valid. Register step: linear step = rom_dout; exponential decrease step = (rom_dout × env_level) >> 15 (14×15 → 29-bit product). Go to CALC.
  - CALC: write env_level, possibly change phase, pulse env_valid. Go to IDLE.
- Address selection per phase:
  - ATTACK: attack_rate. If attack_exp=1 and env_level > 0x6000, use min(attack_rate+8, 0x7F).
  - Sustain increase with exponential mode: same +8 rule using sustain_rate.
  - All other cases: the field given in the port list.
- Increase: sum = level + step (16-bit), clamped to 0x7FFF.
- Decrease: diff = level − step (16-bit signed), clamped to 0.
- ATTACK: increase. When the result reaches 0x7FFF, move to DECAY.
- DECAY: exponential decrease. When the new level ≤ sustain target, move to SUSTAIN. The level is not snapped to the target.
- SUSTAIN: direction and mode from the sustain inputs. Clamps at 0 or 0x7FFF and stays in SUSTAIN indefinitely.
- RELEASE: decrease. When the new level = 0, move to OFF.
- OFF: ticks are ignored; no ROM read and no env_valid.
- key_on in any state: level=0, phase=ATTACK, in-flight update aborted (FSM → IDLE, no env_valid).
- key_off in any state except OFF: phase=RELEASE, level kept, in-flight update aborted.
- key_on and key_off in the same cycle: key_on wins.
- A key event arriving in the same cycle as sample_tick is applied, and that tick is dropped.
- sample_tick while the FSM is not IDLE is ignored.

## Timing
- Reset values: env_level=0, env_phase=0 (OFF), rom_adrs=0, rom_read=0, env_valid=0, FSM=IDLE.
- Reset asserted mid-pipeline returns everything to the reset values on the next edge. No env_valid is produced for the aborted tick.
- Latency: tick sampled at edge E0 → rom_adrs/rom_read valid after E0 → ROM latches at E1 → step registered at E2 → env_level, env_phase and env_valid update at E3.
- env_valid is high for exactly one cycle after E3.
- Key events take effect at the edge at which they are sampled. env_phase reflects the event one cycle later.

## Configuration
- ENV_EXP_EN defined: exponential decrease (multiplier) and the exponential +8 increase rule are built.
- ENV_EXP_EN undefined: attack_exp, sustain_exp and release_exp are ignored and treated as linear, and decay uses linear decrease. No multiplier is instantiated. Latency is unchanged.

## Test plan
- Reset → env_level=0, env_phase=0, rom_read=0, env_valid=0. Ticks in OFF produce no rom_read.
- attack_rate=0, linear, key_on, three ticks → rom_adrs=0x00. Levels are 14336, 28672, then 32767 with phase DECAY. Each env_valid is 3 cycles after its tick.
- With ENV_EXP_EN defined: decay_shift=0, sustain_level=7, starting from 0x7FFF → levels 18432 (DECAY), then 10368 with phase SUSTAIN.
- Linear release, release_shift=0x0B (address 0x2C, step 7), level 20 → 13, 6, 0, then phase OFF; subsequent ticks are ignored.
- With ENV_EXP_EN defined: exponential attack, attack_rate=0x20, run until level > 0x6000 → next rom_adrs=0x28 and the increment is 14. With the macro undefined → rom_adrs stays 0x20 and the increment is 56.
- key_off one cycle after a tick in ATTACK → no env_valid for that tick, phase=RELEASE, level unchanged. key_on and key_off in the same cycle → ATTACK with level 0.
